// File: rtl/accum_job_dispatcher_if.sv
// Signal bundle around the accumulator job dispatcher: job request stream,
// response stream, the accumulator go/done contract and the busy flag.
interface accum_job_dispatcher_if;
  logic [71:0] job_msg;
  logic        job_val;
  logic        job_rdy;
  logic [39:0] resp_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic        accum_go;
  logic [31:0] accum_base_addr;
  logic [31:0] accum_size;
  logic        accum_done;
  logic [31:0] accum_result;
  logic        busy;

  // slave is the dispatcher; master is its environment (producer, consumer, accumulator)
  modport slave (
    input  job_msg, job_val, resp_rdy, accum_done, accum_result,
    output job_rdy, resp_msg, resp_val, accum_go, accum_base_addr, accum_size, busy
  );

  modport master (
    output job_msg, job_val, resp_rdy, accum_done, accum_result,
    input  job_rdy, resp_msg, resp_val, accum_go, accum_base_addr, accum_size, busy
  );
endinterface

// File: rtl/accum_job_dispatcher.sv
// Buffers accumulator jobs in a small FIFO, runs one job at a time through the
// accumulator go/done contract and returns {opaque, result} on a val/rdy stream.
module accum_job_dispatcher #(
  parameter int unsigned JOBQ_ENTRIES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  accum_job_dispatcher_if.slave  bus
);

  localparam int unsigned PTR_W = (JOBQ_ENTRIES > 1) ? $clog2(JOBQ_ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(JOBQ_ENTRIES + 1);

  typedef enum logic [1:0] {IDLE, GO, WAIT, RESP} state_e;

  state_e             state_q;
  logic [71:0]        mem_q [JOBQ_ENTRIES];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         opaque_q;
  logic [31:0]        base_q;
  logic [31:0]        size_q;
  logic [31:0]        result_q;
  logic               go_q;
  logic               resp_val_q;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;
  logic [71:0]        head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(JOBQ_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(JOBQ_ENTRIES));
  assign empty = (count_q == '0);
  assign enq   = bus.job_val && !full;
  assign deq   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= bus.job_msg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      opaque_q   <= '0;
      base_q     <= '0;
      size_q     <= '0;
      result_q   <= '0;
      go_q       <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      go_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            opaque_q <= head[71:64];
            size_q   <= head[63:32];
            base_q   <= head[31:0];
            // Zero-length jobs never start the accumulator and report a zero sum.
            if (head[63:32] == 32'd0) begin
              result_q   <= '0;
              resp_val_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              go_q    <= 1'b1;
              state_q <= GO;
            end
          end
        end
        GO: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.accum_done) begin
            result_q   <= bus.accum_result;
            resp_val_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_rdy) begin
            resp_val_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.job_rdy         = !full;
  assign bus.resp_val        = resp_val_q;
  assign bus.resp_msg        = resp_val_q ? {opaque_q, result_q} : 40'd0;
  assign bus.accum_go        = go_q;
  assign bus.accum_base_addr = base_q;
  assign bus.accum_size      = size_q;
  assign bus.busy            = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_accum_job_dispatcher.sv
// Self-checking bench for accum_job_dispatcher: a behavioural accumulator and a
// response monitor run alongside scenario tasks that compare against expected values.
module tb_accum_job_dispatcher;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  accum_job_dispatcher_if bus ();

  accum_job_dispatcher #(.JOBQ_ENTRIES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;
  int cyc = 0;

  int goCount = 0;
  int doneCyc = 0;
  int overlapErr = 0;
  int stableErr = 0;
  int zeroMsgErr = 0;
  int goCyc[$];
  logic [39:0] gotMsg[$];
  int gotCyc[$];

  int accLatency = 3;
  bit latRandom = 1'b0;
  bit spurInGo = 1'b0;
  int spurIdleReq = 0;
  int spurIdleSrv = 0;

  // Accumulator memory image: word at byte address a holds ((a>>2) & 0xFF) + 1.
  function automatic logic [31:0] accumSum(input logic [31:0] base, input logic [31:0] size);
    logic [31:0] s;
    s = '0;
    for (int unsigned i = 0; i < size; i++) begin
      s = s + (((base + 32'(4 * i)) >> 2) & 32'hFF) + 32'd1;
    end
    return s;
  endfunction

  function automatic logic [39:0] msgAt(input int idx);
    return (idx < gotMsg.size()) ? gotMsg[idx] : 40'hx;
  endfunction

  function automatic int respCycAt(input int idx);
    return (idx < gotCyc.size()) ? gotCyc[idx] : -1;
  endfunction

  function automatic int goCycAt(input int idx);
    return (idx < goCyc.size()) ? goCyc[idx] : -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Accumulator model: reacts at the falling edge, so its outputs are stable at the next rising edge.
  initial begin : accumModel
    int remaining;
    logic [31:0] capBase;
    logic [31:0] capSize;
    bit pending;
    pending = 1'b0;
    remaining = 0;
    capBase = '0;
    capSize = '0;
    bus.accum_done = 1'b0;
    bus.accum_result = '0;
    forever begin
      @(negedge clk);
      bus.accum_done = 1'b0;
      bus.accum_result = $urandom;
      if (!reset_n) begin
        pending = 1'b0;
      end else begin
        if (spurIdleReq != spurIdleSrv) begin
          spurIdleSrv = spurIdleReq;
          bus.accum_done = 1'b1;
          bus.accum_result = 32'hDEADBEEF;
        end
        if (bus.accum_go) begin
          if (pending) overlapErr++;
          goCount++;
          goCyc.push_back(cyc);
          pending = 1'b1;
          capBase = bus.accum_base_addr;
          capSize = bus.accum_size;
          remaining = latRandom ? int'($urandom_range(0, 6)) : accLatency;
          if (spurInGo) begin
            bus.accum_done = 1'b1;
            bus.accum_result = 32'hDEADBEEF;
          end
        end else if (pending) begin
          if (bus.accum_base_addr !== capBase || bus.accum_size !== capSize) stableErr++;
          if (remaining == 0) begin
            bus.accum_done = 1'b1;
            bus.accum_result = accumSum(capBase, capSize);
            doneCyc = cyc;
            pending = 1'b0;
          end else begin
            remaining--;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      if (!bus.resp_val && bus.resp_msg !== 40'd0) zeroMsgErr++;
      if (bus.resp_val && bus.resp_rdy) begin
        gotMsg.push_back(bus.resp_msg);
        gotCyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sendJob(input logic [7:0] op, input logic [31:0] size, input logic [31:0] base,
                         output int acc);
    int n;
    n = 0;
    bus.job_msg = {op, size, base};
    bus.job_val = 1'b1;
    while (!bus.job_rdy && n < 500) begin
      tick();
      n++;
    end
    if (!bus.job_rdy) begin
      checkCount++;
      $display("[TB] FAIL job_accept_timeout: got job_rdy=0 required job_rdy=1 within 500 cycles");
    end
    acc = cyc;
    tick();
    bus.job_val = 1'b0;
    bus.job_msg = '0;
  endtask

  task automatic waitResps(input int target);
    int k;
    k = 0;
    while (gotMsg.size() < target && k < 2000) begin
      tick();
      k++;
    end
    if (gotMsg.size() < target) begin
      checkCount++;
      $display("[TB] FAIL resp_timeout: got %0d responses required %0d", gotMsg.size(), target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_busy_in_reset: got %b required 0", bus.busy); else passCount++;
    checkCount++; if (bus.accum_go !== 1'b0) $display("[TB] FAIL rst_go_in_reset: got %b required 0", bus.accum_go); else passCount++;
    reset_n = 1'b1;
    repeat (2) tick();
    checkCount++; if (bus.job_rdy !== 1'b1) $display("[TB] FAIL rst_job_rdy: got %b required 1", bus.job_rdy); else passCount++;
    checkCount++; if (bus.resp_val !== 1'b0) $display("[TB] FAIL rst_resp_val: got %b required 0", bus.resp_val); else passCount++;
    checkCount++; if (bus.resp_msg !== 40'd0) $display("[TB] FAIL rst_resp_msg: got %h required 0", bus.resp_msg); else passCount++;
    checkCount++; if (bus.accum_base_addr !== 32'd0) $display("[TB] FAIL rst_base: got %h required 0", bus.accum_base_addr); else passCount++;
    checkCount++; if (bus.accum_size !== 32'd0) $display("[TB] FAIL rst_size: got %h required 0", bus.accum_size); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b required 0", bus.busy); else passCount++;
  endtask

  task automatic test_single_job();
    int r0, g0, acc;
    r0 = gotMsg.size();
    g0 = goCount;
    accLatency = 5;
    sendJob(8'h11, 32'd4, 32'h1000, acc);
    waitResps(r0 + 1);
    tick();
    checkCount++; if (goCount - g0 !== 1) $display("[TB] FAIL single_go_count: got %0d required 1", goCount - g0); else passCount++;
    checkCount++; if (goCycAt(g0) !== acc + 2) $display("[TB] FAIL single_go_latency: got cycle %0d required %0d", goCycAt(g0), acc + 2); else passCount++;
    checkCount++; if (msgAt(r0) !== 40'h11_0000000A) $display("[TB] FAIL single_resp_msg: got %h required 110000000a", msgAt(r0)); else passCount++;
    checkCount++; if (respCycAt(r0) !== doneCyc + 1) $display("[TB] FAIL single_resp_latency: got cycle %0d required %0d", respCycAt(r0), doneCyc + 1); else passCount++;
    checkCount++; if (stableErr !== 0) $display("[TB] FAIL single_operand_stable: got %0d changes required 0", stableErr); else passCount++;
  endtask

  task automatic test_zero_size();
    int r0, g0, acc;
    r0 = gotMsg.size();
    g0 = goCount;
    sendJob(8'h22, 32'd0, 32'hABC0, acc);
    waitResps(r0 + 1);
    repeat (3) tick();
    checkCount++; if (goCount !== g0) $display("[TB] FAIL zero_no_go: got %0d pulses required 0", goCount - g0); else passCount++;
    checkCount++; if (msgAt(r0) !== 40'h22_00000000) $display("[TB] FAIL zero_resp_msg: got %h required 2200000000", msgAt(r0)); else passCount++;
    checkCount++; if (respCycAt(r0) !== acc + 2) $display("[TB] FAIL zero_resp_latency: got cycle %0d required %0d", respCycAt(r0), acc + 2); else passCount++;
  endtask

  task automatic test_back_to_back();
    int r0, g0, acc;
    logic [7:0]  ops[3];
    logic [31:0] sizes[3];
    logic [31:0] bases[3];
    logic [39:0] exp;
    ops = '{8'h01, 8'h02, 8'h03};
    sizes = '{32'd3, 32'd5, 32'd2};
    bases = '{32'h100, 32'h200, 32'h300};
    r0 = gotMsg.size();
    g0 = goCount;
    accLatency = 20;
    for (int i = 0; i < 3; i++) sendJob(ops[i], sizes[i], bases[i], acc);
    checkCount++; if (bus.job_rdy !== 1'b0) $display("[TB] FAIL b2b_job_rdy_full: got %b required 0", bus.job_rdy); else passCount++;
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_busy: got %b required 1", bus.busy); else passCount++;
    waitResps(r0 + 3);
    tick();
    checkCount++; if (goCount - g0 !== 3) $display("[TB] FAIL b2b_go_count: got %0d required 3", goCount - g0); else passCount++;
    for (int i = 0; i < 3; i++) begin
      exp = {ops[i], accumSum(bases[i], sizes[i])};
      checkCount++; if (msgAt(r0 + i) !== exp) $display("[TB] FAIL b2b_resp_order[%0d]: got %h required %h", i, msgAt(r0 + i), exp); else passCount++;
    end
    accLatency = 3;
  endtask

  task automatic test_resp_stall();
    int r0, g0, acc, k;
    logic [39:0] expB;
    r0 = gotMsg.size();
    accLatency = 2;
    bus.resp_rdy = 1'b0;
    g0 = goCount;
    sendJob(8'h44, 32'd0, 32'h0, acc);
    sendJob(8'h45, 32'd2, 32'h40, acc);
    k = 0;
    while (!bus.resp_val && k < 50) begin
      tick();
      k++;
    end
    checkCount++; if (bus.resp_msg !== 40'h44_00000000) $display("[TB] FAIL stall_first_msg: got %h required 4400000000", bus.resp_msg); else passCount++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++; if (bus.resp_val !== 1'b1 || bus.resp_msg !== 40'h44_00000000 || bus.accum_go !== 1'b0)
        $display("[TB] FAIL stall_hold[%0d]: got val=%b msg=%h go=%b required val=1 msg=4400000000 go=0", i, bus.resp_val, bus.resp_msg, bus.accum_go);
      else passCount++;
    end
    checkCount++; if (goCount !== g0) $display("[TB] FAIL stall_no_go: got %0d pulses required 0", goCount - g0); else passCount++;
    checkCount++; if (gotMsg.size() !== r0) $display("[TB] FAIL stall_no_handshake: got %0d responses required 0", gotMsg.size() - r0); else passCount++;
    bus.resp_rdy = 1'b1;
    waitResps(r0 + 2);
    tick();
    expB = {8'h45, accumSum(32'h40, 32'd2)};
    checkCount++; if (msgAt(r0) !== 40'h44_00000000) $display("[TB] FAIL stall_resp_a: got %h required 4400000000", msgAt(r0)); else passCount++;
    checkCount++; if (msgAt(r0 + 1) !== expB) $display("[TB] FAIL stall_resp_b: got %h required %h", msgAt(r0 + 1), expB); else passCount++;
    checkCount++; if (goCount !== g0 + 1) $display("[TB] FAIL stall_go_after: got %0d pulses required 1", goCount - g0); else passCount++;
    accLatency = 3;
  endtask

  task automatic test_spurious_done();
    int r0, g0, acc;
    r0 = gotMsg.size();
    g0 = goCount;
    spurIdleReq++;
    repeat (3) tick();
    checkCount++; if (bus.busy !== 1'b0 || bus.resp_val !== 1'b0)
      $display("[TB] FAIL spur_idle_ignored: got busy=%b resp_val=%b required 0/0", bus.busy, bus.resp_val);
    else passCount++;
    checkCount++; if (gotMsg.size() !== r0) $display("[TB] FAIL spur_idle_no_resp: got %0d responses required 0", gotMsg.size() - r0); else passCount++;
    spurInGo = 1'b1;
    accLatency = 2;
    sendJob(8'h55, 32'd3, 32'h2000, acc);
    waitResps(r0 + 1);
    tick();
    spurInGo = 1'b0;
    checkCount++; if (msgAt(r0) !== 40'h55_00000006) $display("[TB] FAIL spur_go_result: got %h required 5500000006", msgAt(r0)); else passCount++;
    checkCount++; if (respCycAt(r0) !== doneCyc + 1) $display("[TB] FAIL spur_go_latency: got cycle %0d required %0d", respCycAt(r0), doneCyc + 1); else passCount++;
    checkCount++; if (goCount - g0 !== 1) $display("[TB] FAIL spur_go_count: got %0d required 1", goCount - g0); else passCount++;
    accLatency = 3;
  endtask

  task automatic test_random();
    int r0;
    logic [39:0] expQ[$];
    r0 = gotMsg.size();
    latRandom = 1'b1;
    fork
      begin : sender
        int acc;
        logic [7:0]  op;
        logic [31:0] size;
        logic [31:0] base;
        for (int i = 0; i < 40; i++) begin
          op = 8'($urandom);
          size = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
          base = $urandom & 32'hFFFF_FFFC;
          expQ.push_back({op, accumSum(base, size)});
          sendJob(op, size, base, acc);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin : drainer
        int k;
        k = 0;
        while (gotMsg.size() < r0 + 40 && k < 6000) begin
          bus.resp_rdy = ($urandom_range(0, 3) != 0);
          tick();
          k++;
        end
      end
    join
    bus.resp_rdy = 1'b1;
    latRandom = 1'b0;
    waitResps(r0 + 40);
    tick();
    for (int i = 0; i < 40; i++) begin
      checkCount++; if (msgAt(r0 + i) !== expQ[i]) $display("[TB] FAIL random_resp[%0d]: got %h required %h", i, msgAt(r0 + i), expQ[i]); else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    int r0, g0, g1, acc, k;
    r0 = gotMsg.size();
    g0 = goCount;
    accLatency = 40;
    sendJob(8'h61, 32'd6, 32'h500, acc);
    sendJob(8'h62, 32'd3, 32'h600, acc);
    k = 0;
    while (goCount == g0 && k < 50) begin
      tick();
      k++;
    end
    repeat (3) tick();
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL rmid_busy_before: got %b required 1", bus.busy); else passCount++;
    #2 reset_n = 1'b0;
    #1;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL rmid_busy: got %b required 0", bus.busy); else passCount++;
    checkCount++; if (bus.resp_val !== 1'b0 || bus.resp_msg !== 40'd0)
      $display("[TB] FAIL rmid_resp: got val=%b msg=%h required 0/0", bus.resp_val, bus.resp_msg);
    else passCount++;
    checkCount++; if (bus.accum_base_addr !== 32'd0 || bus.accum_size !== 32'd0 || bus.accum_go !== 1'b0)
      $display("[TB] FAIL rmid_accum_regs: got base=%h size=%h go=%b required 0/0/0", bus.accum_base_addr, bus.accum_size, bus.accum_go);
    else passCount++;
    repeat (2) tick();
    reset_n = 1'b1;
    g1 = goCount;
    repeat (60) tick();
    checkCount++; if (goCount !== g1) $display("[TB] FAIL rmid_no_go_after: got %0d pulses required 0", goCount - g1); else passCount++;
    checkCount++; if (gotMsg.size() !== r0) $display("[TB] FAIL rmid_no_resp_after: got %0d responses required 0", gotMsg.size() - r0); else passCount++;
    checkCount++; if (bus.busy !== 1'b0 || bus.job_rdy !== 1'b1)
      $display("[TB] FAIL rmid_idle_after: got busy=%b job_rdy=%b required 0/1", bus.busy, bus.job_rdy);
    else passCount++;
    accLatency = 3;
  endtask

  task automatic test_invariants();
    checkCount++; if (overlapErr !== 0) $display("[TB] FAIL inv_go_overlap: got %0d required 0", overlapErr); else passCount++;
    checkCount++; if (stableErr !== 0) $display("[TB] FAIL inv_operand_stable: got %0d required 0", stableErr); else passCount++;
    checkCount++; if (zeroMsgErr !== 0) $display("[TB] FAIL inv_idle_msg_zero: got %0d required 0", zeroMsgErr); else passCount++;
  endtask

  initial begin
    bus.job_val = 1'b0;
    bus.job_msg = '0;
    bus.resp_rdy = 1'b1;
    test_reset();
    test_single_job();
    test_zero_size();
    test_back_to_back();
    test_resp_stall();
    test_spurious_done();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
